param_processor: RTL and testbench

Parametrised multi-cycle successor to `simple_processor`. It adds:
- configurable data width, register count and instruction-memory depth;
- a loadable instruction memory;
- a run/halt handshake;
- zero and carry flags with a conditional jump;
- a debug register read port.

It is a standalone top-level compute block driven only by its load/run interface.

---
 rtl/param_proc_pkg.sv | 65 ++++++
 rtl/param_proc_if.sv | 32 +++
 rtl/proc_alu.sv | 54 +++++
 rtl/param_processor.sv | 116 +++++++++++
 tb/tb_param_processor.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/param_proc_pkg.sv
// Shared opcode/state encodings and instruction field helpers for param_processor.
// Optional feature macro: PARAM_PROC_MUL_EN (opcode 12 becomes MUL).
package param_proc_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_LDI  = 4'd1,
      OP_MOV  = 4'd2,
      OP_ADD  = 4'd3,
      OP_SUB  = 4'd4,
      OP_AND  = 4'd5,
      OP_OR   = 4'd6,
      OP_XOR  = 4'd7,
      OP_ADDI = 4'd8,
      OP_JMP  = 4'd9,
      OP_JZ   = 4'd10,
      OP_HALT = 4'd11,
      OP_MUL  = 4'd12
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALT
   } state_e;

   // Instructions are handled as zero-extended 64-bit words, so INSTR_W must not exceed 64.
   function automatic logic [3:0] f_opcode(input logic [63:0] instr, input int ra_w, input int data_w);
      return 4'((instr >> (2 * ra_w + data_w)) & 64'hF);
   endfunction

   function automatic logic [63:0] f_rd(input logic [63:0] instr, input int ra_w, input int data_w);
      return (instr >> (ra_w + data_w)) & ((64'd1 << ra_w) - 64'd1);
   endfunction

   function automatic logic [63:0] f_rs(input logic [63:0] instr, input int ra_w, input int data_w);
      return (instr >> data_w) & ((64'd1 << ra_w) - 64'd1);
   endfunction

   function automatic logic [63:0] f_imm(input logic [63:0] instr, input int data_w);
      return instr & ((64'd1 << data_w) - 64'd1);
   endfunction

   function automatic logic f_uses_imm(input logic [3:0] op);
      return (op == OP_LDI) || (op == OP_ADDI) || (op == OP_JMP) || (op == OP_JZ);
   endfunction

   function automatic logic f_updates_flags(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: return 1'b1;
`ifdef PARAM_PROC_MUL_EN
         OP_MUL: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic f_writes_rd(input logic [3:0] op);
      return (op == OP_LDI) || (op == OP_MOV) || f_updates_flags(op);
   endfunction

endpackage

// File: rtl/param_proc_if.sv
// Load/run/debug bundle between a controller (master) and param_processor (slave).
interface param_proc_if #(
   parameter int DATA_W     = 8,
   parameter int REG_CNT    = 4,
   parameter int IMEM_DEPTH = 16
);
   localparam int RA_W    = $clog2(REG_CNT);
   localparam int PC_W    = $clog2(IMEM_DEPTH);
   localparam int INSTR_W = 4 + 2 * RA_W + DATA_W;

   logic               load_en;
   logic [PC_W-1:0]    load_addr;
   logic [INSTR_W-1:0] load_data;
   logic               run;
   logic               busy;
   logic               halted;
   logic [PC_W-1:0]    pc;
   logic               zero_flag;
   logic               carry_flag;
   logic [RA_W-1:0]    dbg_sel;
   logic [DATA_W-1:0]  dbg_data;

   modport master (
      output load_en, load_addr, load_data, run, dbg_sel,
      input  busy, halted, pc, zero_flag, carry_flag, dbg_data
   );

   modport slave (
      input  load_en, load_addr, load_data, run, dbg_sel,
      output busy, halted, pc, zero_flag, carry_flag, dbg_data
   );
endinterface

// File: rtl/proc_alu.sv
// Combinational ALU for param_processor: result plus zero/carry flags.
// Optional feature macro: PARAM_PROC_MUL_EN (adds the opcode 12 multiplier).
module proc_alu
   import param_proc_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [3:0]        opcode,
   input  logic [DATA_W-1:0] opa,
   input  logic [DATA_W-1:0] opb,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              carry
);
   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   // The extra top bit is the carry-out for add and the borrow for subtract.
   assign sum  = {1'b0, opa} + {1'b0, opb};
   assign diff = {1'b0, opa} - {1'b0, opb};

`ifdef PARAM_PROC_MUL_EN
   logic [2*DATA_W-1:0] prod;
   assign prod = {{DATA_W{1'b0}}, opa} * {{DATA_W{1'b0}}, opb};
`endif

   always_comb begin
      result = opa;
      carry  = 1'b0;
      case (opcode)
         OP_LDI, OP_MOV:  result = opb;
         OP_ADD, OP_ADDI: begin
            result = sum[DATA_W-1:0];
            carry  = sum[DATA_W];
         end
         OP_SUB: begin
            result = diff[DATA_W-1:0];
            carry  = diff[DATA_W];
         end
         OP_AND: result = opa & opb;
         OP_OR:  result = opa | opb;
         OP_XOR: result = opa ^ opb;
`ifdef PARAM_PROC_MUL_EN
         OP_MUL: begin
            result = prod[DATA_W-1:0];
            carry  = |prod[2*DATA_W-1:DATA_W];
         end
`endif
         default: ;
      endcase
   end

   assign zero = (result == '0);
endmodule

// File: rtl/param_processor.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK processor with loadable imem and debug port.
module param_processor
   import param_proc_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int REG_CNT    = 4,
   parameter int IMEM_DEPTH = 16
) (
   input  logic         clk,
   input  logic         reset,
   param_proc_if.slave  bus
);
   localparam int RA_W    = $clog2(REG_CNT);
   localparam int PC_W    = $clog2(IMEM_DEPTH);
   localparam int INSTR_W = 4 + 2 * RA_W + DATA_W;

   state_e              state_q, state_d;
   logic [PC_W-1:0]     pc_q;
   logic [INSTR_W-1:0]  ir_q;
   logic [DATA_W-1:0]   opa_q, opb_q, res_q;
   logic                zero_q, carry_q;
   logic [DATA_W-1:0]   rf_q [REG_CNT];
   logic [INSTR_W-1:0]  imem [IMEM_DEPTH];

   logic [3:0]          op;
   logic [RA_W-1:0]     rd, rs;
   logic [DATA_W-1:0]   imm;
   logic [DATA_W-1:0]   alu_result;
   logic                alu_zero, alu_carry;
   logic                parked, load_ok, start;

   assign op  = f_opcode(64'(ir_q), RA_W, DATA_W);
   assign rd  = RA_W'(f_rd(64'(ir_q), RA_W, DATA_W));
   assign rs  = RA_W'(f_rs(64'(ir_q), RA_W, DATA_W));
   assign imm = DATA_W'(f_imm(64'(ir_q), DATA_W));

   // Load has priority over run; both only act while parked in IDLE or HALT.
   assign parked  = (state_q == S_IDLE) || (state_q == S_HALT);
   assign load_ok = parked && bus.load_en;
   assign start   = parked && !bus.load_en && bus.run;

   proc_alu #(.DATA_W(DATA_W)) u_alu (
      .opcode (op),
      .opa    (opa_q),
      .opb    (opb_q),
      .result (alu_result),
      .zero   (alu_zero),
      .carry  (alu_carry)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_HALT: if (start) state_d = S_FETCH;
         S_FETCH:        state_d = S_DECODE;
         S_DECODE:       state_d = S_EXECUTE;
         S_EXECUTE:      state_d = S_WRITEBACK;
         S_WRITEBACK:    state_d = (op == OP_HALT) ? S_HALT : S_FETCH;
         default:        state_d = S_IDLE;
      endcase
   end

   // Instruction memory is deliberately left out of reset so a program survives it.
   always_ff @(posedge clk) begin
      if (load_ok) imem[bus.load_addr] <= bus.load_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= '0;
         ir_q    <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         for (int i = 0; i < REG_CNT; i++) rf_q[i] <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_HALT: if (start) pc_q <= '0;
            S_FETCH:        ir_q <= imem[pc_q];
            S_DECODE: begin
               opa_q <= rf_q[rd];
               opb_q <= f_uses_imm(op) ? imm : rf_q[rs];
            end
            S_EXECUTE: begin
               res_q <= alu_result;
               if (f_updates_flags(op)) begin
                  zero_q  <= alu_zero;
                  carry_q <= alu_carry;
               end
            end
            S_WRITEBACK: begin
               if (f_writes_rd(op)) rf_q[rd] <= res_q;
               // HALT leaves pc on its own address.
               if (op == OP_JMP || (op == OP_JZ && zero_q)) pc_q <= PC_W'(imm);
               else if (op != OP_HALT)                     pc_q <= pc_q + PC_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                           (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
   assign bus.halted     = (state_q == S_HALT);
   assign bus.pc         = pc_q;
   assign bus.zero_flag  = zero_q;
   assign bus.carry_flag = carry_q;
   assign bus.dbg_data   = rf_q[bus.dbg_sel];
endmodule

// File: tb/tb_param_processor.sv
// Directed-vector bench for param_processor (DATA_W=8, REG_CNT=4, IMEM_DEPTH=16).
module tb_param_processor;
   import param_proc_pkg::*;

   localparam int DATA_W     = 8;
   localparam int REG_CNT    = 4;
   localparam int IMEM_DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset;
   int          vectors = 0;
   int          errors  = 0;
   int          cyc;
   logic [3:0]  pc4, pc8;
   logic        mul_carry_exp;

   param_proc_if #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .IMEM_DEPTH(IMEM_DEPTH)) bus ();

   param_processor #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .IMEM_DEPTH(IMEM_DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
      return {op, rd, rs, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic rchk(input string tag, input logic [1:0] sel, input logic [31:0] exp);
      bus.dbg_sel = sel;
      #1;
      chk(tag, 32'(bus.dbg_data), exp);
   endtask

   task automatic load(input logic [3:0] a, input logic [15:0] d);
      bus.load_en   = 1'b1;
      bus.load_addr = a;
      bus.load_data = d;
      @(negedge clk);
      bus.load_en   = 1'b0;
   endtask

   // Pulses run, then counts cycles until halted (bounded); poke hits run/load while busy.
   task automatic run_prog(input string name, input bit poke, output int n,
                           output logic [3:0] p4, output logic [3:0] p8);
      p4 = 'x;
      p8 = 'x;
      bus.run = 1'b1;
      @(negedge clk);
      bus.run = 1'b0;
      n = 0;
      while (bus.halted !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
         if (poke && n == 2) begin
            bus.run       = 1'b1;
            bus.load_en   = 1'b1;
            bus.load_addr = 4'd1;
            bus.load_data = 16'h0000;
         end else begin
            bus.run     = 1'b0;
            bus.load_en = 1'b0;
         end
         if (n == 4) p4 = bus.pc;
         if (n == 8) p8 = bus.pc;
      end
      $display("run %s: cycles=%0d pc=%0d zero=%0b carry=%0b", name, n, bus.pc,
               bus.zero_flag, bus.carry_flag);
   endtask

   initial begin
      reset         = 1'b0;
      bus.load_en   = 1'b0;
      bus.load_addr = '0;
      bus.load_data = '0;
      bus.run       = 1'b0;
      bus.dbg_sel   = '0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_halted", 32'(bus.halted), 0);
      chk("rst_pc", 32'(bus.pc), 0);
      chk("rst_zero", 32'(bus.zero_flag), 0);
      chk("rst_carry", 32'(bus.carry_flag), 0);
      for (int i = 0; i < REG_CNT; i++) rchk("rst_rf", 2'(i), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Reset mid-run, plus first-write latency
      load(4'd0, enc(OP_LDI, 2'd0, 2'd0, 8'd5));
      load(4'd1, enc(OP_LDI, 2'd1, 2'd0, 8'd3));
      load(4'd2, enc(OP_ADD, 2'd0, 2'd1, 8'd0));
      load(4'd3, enc(OP_HALT, 2'd0, 2'd0, 8'd0));
      bus.run = 1'b1;
      @(negedge clk);
      bus.run = 1'b0;
      repeat (3) @(negedge clk);
      rchk("wr_before_n4", 2'd0, 0);
      @(negedge clk);
      rchk("wr_at_n4", 2'd0, 5);
      repeat (2) @(negedge clk);
      chk("midrun_busy", 32'(bus.busy), 1);
      chk("midrun_pc", 32'(bus.pc), 1);
      reset = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 0);
      chk("arst_halted", 32'(bus.halted), 0);
      chk("arst_pc", 32'(bus.pc), 0);
      rchk("arst_r0", 2'd0, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Basic program, reloaded imem retained across reset
      run_prog("basic", 1'b0, cyc, pc4, pc8);
      chk("basic_cycles", 32'(cyc), 16);
      chk("basic_halted", 32'(bus.halted), 1);
      chk("basic_busy", 32'(bus.busy), 0);
      chk("basic_pc", 32'(bus.pc), 3);
      rchk("basic_r0", 2'd0, 8);
      chk("basic_zero", 32'(bus.zero_flag), 0);
      chk("basic_carry", 32'(bus.carry_flag), 0);

      // ADDI overflow to zero
      load(4'd0, enc(OP_LDI, 2'd0, 2'd0, 8'd200));
      load(4'd1, enc(OP_ADDI, 2'd0, 2'd0, 8'd56));
      load(4'd2, enc(OP_HALT, 2'd0, 2'd0, 8'd0));
      run_prog("addi_wrap", 1'b0, cyc, pc4, pc8);
      chk("addi_cycles", 32'(cyc), 12);
      rchk("addi_r0", 2'd0, 0);
      chk("addi_zero", 32'(bus.zero_flag), 1);
      chk("addi_carry", 32'(bus.carry_flag), 1);

      // SUB with borrow: 3 - 5 = 254 mod 256
      load(4'd0, enc(OP_LDI, 2'd0, 2'd0, 8'd3));
      load(4'd1, enc(OP_LDI, 2'd1, 2'd0, 8'd5));
      load(4'd2, enc(OP_SUB, 2'd0, 2'd1, 8'd0));
      load(4'd3, enc(OP_HALT, 2'd0, 2'd0, 8'd0));
      run_prog("sub_borrow", 1'b0, cyc, pc4, pc8);
      rchk("sub_r0", 2'd0, 254);
      chk("sub_carry", 32'(bus.carry_flag), 1);
      chk("sub_zero", 32'(bus.zero_flag), 0);

      // Handshake: reset clears flags, load beats run, run/load ignored while busy
      reset = 1'b0;
      #1;
      chk("arst_carry", 32'(bus.carry_flag), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      load(4'd1, enc(OP_HALT, 2'd0, 2'd0, 8'd0));
      bus.run = 1'b1;
      load(4'd0, enc(OP_LDI, 2'd3, 2'd0, 8'h5A));
      bus.run = 1'b0;
      chk("collide_busy", 32'(bus.busy), 0);
      chk("collide_halted", 32'(bus.halted), 0);
      run_prog("busy_poke", 1'b1, cyc, pc4, pc8);
      chk("poke_cycles", 32'(cyc), 8);
      chk("poke_pc", 32'(bus.pc), 1);
      rchk("collide_r3", 2'd3, 32'h5A);

      // Countdown loop: 3 iterations, r2 counts them
      load(4'd0, enc(OP_LDI, 2'd0, 2'd0, 8'd3));
      load(4'd1, enc(OP_LDI, 2'd1, 2'd0, 8'd1));
      load(4'd2, enc(OP_LDI, 2'd2, 2'd0, 8'd0));
      load(4'd3, enc(OP_ADDI, 2'd2, 2'd0, 8'd1));
      load(4'd4, enc(OP_SUB, 2'd0, 2'd1, 8'd0));
      load(4'd5, enc(OP_JZ, 2'd0, 2'd0, 8'd7));
      load(4'd6, enc(OP_JMP, 2'd0, 2'd0, 8'd3));
      load(4'd7, enc(OP_HALT, 2'd0, 2'd0, 8'd0));
      run_prog("loop", 1'b0, cyc, pc4, pc8);
      chk("loop_cycles", 32'(cyc), 60);
      chk("loop_pc", 32'(bus.pc), 7);
      rchk("loop_iters", 2'd2, 3);
      rchk("loop_r0", 2'd0, 0);
      chk("loop_zero", 32'(bus.zero_flag), 1);

      // PC wrap: JZ (zero still set) to 15, ADDI at 15 wraps pc to 0, JZ falls through to HALT
      load(4'd0, enc(OP_JZ, 2'd0, 2'd0, 8'd15));
      load(4'd1, enc(OP_HALT, 2'd0, 2'd0, 8'd0));
      load(4'd15, enc(OP_ADDI, 2'd0, 2'd0, 8'd1));
      run_prog("pc_wrap", 1'b0, cyc, pc4, pc8);
      chk("wrap_pc_at15", 32'(pc4), 15);
      chk("wrap_pc_to0", 32'(pc8), 0);
      chk("wrap_cycles", 32'(cyc), 16);
      chk("wrap_pc_final", 32'(bus.pc), 1);
      rchk("wrap_r0", 2'd0, 1);

      // MUL 16*17 = 272: low byte 16, high byte nonzero
`ifdef PARAM_PROC_MUL_EN
      mul_carry_exp = 1'b1;
`else
      mul_carry_exp = 1'b0;
`endif
      load(4'd0, enc(OP_LDI, 2'd0, 2'd0, 8'd16));
      load(4'd1, enc(OP_LDI, 2'd1, 2'd0, 8'd17));
      load(4'd2, enc(OP_MUL, 2'd0, 2'd1, 8'd0));
      load(4'd3, enc(OP_HALT, 2'd0, 2'd0, 8'd0));
      run_prog("mul_16x17", 1'b0, cyc, pc4, pc8);
      chk("mul_cycles", 32'(cyc), 16);
      rchk("mul_r0", 2'd0, 16);
      chk("mul_carry", 32'(bus.carry_flag), 32'(mul_carry_exp));

      // MUL 3*17: 51 when enabled, rd untouched when not
      load(4'd0, enc(OP_LDI, 2'd2, 2'd0, 8'd3));
      load(4'd1, enc(OP_MUL, 2'd2, 2'd1, 8'd0));
      load(4'd2, enc(OP_HALT, 2'd0, 2'd0, 8'd0));
      run_prog("mul_3x17", 1'b0, cyc, pc4, pc8);
`ifdef PARAM_PROC_MUL_EN
      rchk("mul_r2", 2'd2, 51);
`else
      rchk("mul_r2", 2'd2, 3);
`endif
      chk("mul2_carry", 32'(bus.carry_flag), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
